// File: rtl/lenet_pkg.sv
// Shared LeNet definitions: slice geometry, accumulator width, element extraction and 8-bit saturation.
package lenet_pkg;

  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned FC_SLICE  = 25;
  localparam int unsigned ACC_W     = 24;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -128;

  // Element i of a packed slice vector; element 0 is the most-significant byte.
  function automatic logic signed [DATA_SIZE-1:0] get_elem(
    input logic [FC_SLICE*DATA_SIZE-1:0] vec,
    input int unsigned                   idx
  );
    return vec[DATA_SIZE*(FC_SLICE-idx)-1 -: DATA_SIZE];
  endfunction

  function automatic logic signed [DATA_SIZE-1:0] sat8(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[DATA_SIZE-1:0];
    if (x < SAT_MIN) return SAT_MIN[DATA_SIZE-1:0];
    return x[DATA_SIZE-1:0];
  endfunction

endpackage

// File: rtl/add_tree.sv
// Combinational signed N-input adder tree, sign-extended to ACC_W bits and reduced pairwise.
module add_tree
  import lenet_pkg::*;
#(
  parameter int unsigned N    = FC_SLICE,
  parameter int unsigned IN_W = 2 * DATA_SIZE
) (
  input  logic signed [IN_W-1:0]  din [N],
  output logic signed [ACC_W-1:0] sum
);

  localparam int unsigned LEVELS = $clog2(N);
  localparam int unsigned LEAVES = 1 << LEVELS;

  logic signed [ACC_W-1:0] lvl [LEVELS+1][LEAVES];

  // Unused leaves stay zero so the tree can be a full power of two.
  always_comb begin
    lvl = '{default: '0};
    for (int i = 0; i < int'(N); i++) begin
      lvl[0][i] = ACC_W'(din[i]);
    end
    for (int l = 0; l < int'(LEVELS); l++) begin
      for (int i = 0; i < int'(LEAVES >> (l + 1)); i++) begin
        lvl[l+1][i] = lvl[l][2*i] + lvl[l][2*i+1];
      end
    end
  end

  assign sum = lvl[LEVELS][0];

endmodule

// File: rtl/multi_add_unit.sv
// 25-element signed dot product plus aligned bias, arithmetic shift, saturation and optional ReLU;
// one registered result per cycle.
module multi_add_unit
  import lenet_pkg::*;
#(
  parameter int unsigned DATA_SIZE = lenet_pkg::DATA_SIZE,
  parameter int unsigned N         = FC_SLICE,
  parameter int unsigned SHIFT     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N*DATA_SIZE-1:0]        matrix1,
  input  logic [N*DATA_SIZE-1:0]        matrix2,
  input  logic signed [DATA_SIZE-1:0]   bias,
  input  logic                          relu_1_en,
  output logic signed [DATA_SIZE-1:0]   dout
);

  localparam int unsigned PROD_W = 2 * DATA_SIZE;

  logic signed [PROD_W-1:0]    prod [N];
  logic signed [ACC_W-1:0]     tree_sum;
  logic signed [ACC_W-1:0]     bias_al_c;
  logic signed [ACC_W-1:0]     acc_c;
  logic signed [ACC_W-1:0]     shifted_c;
  logic signed [DATA_SIZE-1:0] sat_c;
  logic signed [DATA_SIZE-1:0] res_c;

  // Operands widened to the product width so the low 16 bits hold the exact signed product.
  for (genvar i = 0; i < N; i++) begin : g_mul
    assign prod[i] = PROD_W'(get_elem(matrix1, i)) * PROD_W'(get_elem(matrix2, i));
  end

  add_tree #(
    .N    (N),
    .IN_W (PROD_W)
  ) u_add_tree (
    .din (prod),
    .sum (tree_sum)
  );

  // Bias is pre-scaled so it survives the output shift at unit weight.
  always_comb begin
    bias_al_c = ACC_W'(bias) <<< SHIFT;
    acc_c     = tree_sum + bias_al_c;
    shifted_c = acc_c >>> SHIFT;
    sat_c     = sat8(shifted_c);
    res_c     = (relu_1_en && sat_c[DATA_SIZE-1]) ? '0 : sat_c;
  end

  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= res_c;
  end

endmodule

// File: tb/tb_multi_add_unit.sv
// Scoreboard bench for multi_add_unit: SHIFT=0 and SHIFT=2 instances share stimulus, checked against an integer model.
module tb_multi_add_unit;

  logic               clk = 1'b0;
  logic               rst;
  logic [199:0]       matrix1;
  logic [199:0]       matrix2;
  logic signed [7:0]  bias;
  logic               relu_1_en;
  logic signed [7:0]  dout0;
  logic signed [7:0]  dout2;

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e2;
    string      name;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  multi_add_unit #(.SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .matrix1(matrix1), .matrix2(matrix2),
    .bias(bias), .relu_1_en(relu_1_en), .dout(dout0)
  );

  multi_add_unit #(.SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .matrix1(matrix1), .matrix2(matrix2),
    .bias(bias), .relu_1_en(relu_1_en), .dout(dout2)
  );

  // Reference: plain integer dot product, bias scaled by 2**sh, floor shift, clamp, ReLU.
  function automatic logic [7:0] ref_out(input logic [199:0] a, input logic [199:0] b,
                                         input logic [7:0] bs, input logic relu, input int sh);
    int  sum;
    int  s;
    byte ea;
    byte eb;
    sum = 0;
    for (int i = 0; i < 25; i++) begin
      ea = byte'(a >> (8 * (24 - i)));
      eb = byte'(b >> (8 * (24 - i)));
      sum += int'(ea) * int'(eb);
    end
    sum += int'(byte'(bs)) * (1 << sh);
    s = sum >>> sh;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    if (relu && s < 0) s = 0;
    return 8'(s);
  endfunction

  function automatic logic [199:0] fill(input logic [7:0] v);
    logic [199:0] r;
    for (int i = 0; i < 25; i++) r[8*i +: 8] = v;
    return r;
  endfunction

  task automatic apply(input logic [199:0] a, input logic [199:0] b, input logic [7:0] bs,
                       input logic relu, input logic r, input string name);
    exp_t e;
    @(negedge clk);
    matrix1   = a;
    matrix2   = b;
    bias      = bs;
    relu_1_en = relu;
    rst       = r;
    e.name    = name;
    if (r) begin
      e.e0 = 8'h00;
      e.e2 = 8'h00;
    end else begin
      e.e0 = ref_out(a, b, bs, relu, 0);
      e.e2 = ref_out(a, b, bs, relu, 2);
    end
    q.push_back(e);
  endtask

  // Monitor: each queued expectation belongs to the edge following its stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vecs++;
        if (dout0 !== e.e0) begin
          errs++;
          $display("FAIL %s shift0: got %h expected %h", e.name, dout0, e.e0);
        end
        vecs++;
        if (dout2 !== e.e2) begin
          errs++;
          $display("FAIL %s shift2: got %h expected %h", e.name, dout2, e.e2);
        end
      end
    end
  end

  initial begin
    logic [199:0] a;
    logic [199:0] b;
    logic [199:0] z;
    int           mode;
    int           guard;
    z         = '0;
    rst       = 1'b1;
    matrix1   = '0;
    matrix2   = '0;
    bias      = '0;
    relu_1_en = 1'b0;

    apply(fill(8'h7F), fill(8'h7F), 8'h7F, 1'b0, 1'b1, "reset_7f");
    apply('x, 'x, 'x, 'x, 1'b1, "reset_x");
    apply(fill(8'h7F), fill(8'h7F), 8'h7F, 1'b0, 1'b0, "release_7f");
    apply(fill(8'h01), fill(8'h02), 8'h03, 1'b0, 1'b0, "basic_53");
    apply(fill(8'h01), fill(8'hFF), 8'h00, 1'b0, 1'b0, "neg_relu_off");
    apply(fill(8'h01), fill(8'hFF), 8'h00, 1'b1, 1'b0, "neg_relu_on");
    apply(fill(8'h80), fill(8'h7F), 8'h00, 1'b0, 1'b0, "sat_low");
    apply(z, z, 8'h7F, 1'b0, 1'b0, "bias_only");
    a = z; b = z; a[199:192] = 8'd5; b[199:192] = 8'd3;
    apply(a, b, 8'h00, 1'b0, 1'b0, "elem0");
    a = z; b = z; a[7:0] = 8'hFC; b[7:0] = 8'd6;
    apply(a, b, 8'h00, 1'b0, 1'b0, "elem24");
    a = z; b = z; a[199:192] = 8'd9; b[191:184] = 8'd7;
    apply(a, b, 8'h00, 1'b0, 1'b0, "mismatch_pos");
    apply(fill(8'h01), fill(8'h04), 8'h01, 1'b0, 1'b0, "shift_26");
    apply(fill(8'h7F), fill(8'h7F), 8'h7F, 1'b0, 1'b1, "midstream_reset");
    apply(fill(8'hFF), fill(8'h03), 8'h05, 1'b1, 1'b0, "after_reset");

    for (int n = 0; n < 400; n++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 25; i++) begin
        case (mode)
          0: begin
            a[8*i +: 8] = 8'($urandom);
            b[8*i +: 8] = 8'($urandom);
          end
          1: begin
            a[8*i +: 8] = 8'($urandom_range(0, 6) - 3);
            b[8*i +: 8] = 8'($urandom_range(0, 6) - 3);
          end
          default: begin
            a[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            b[8*i +: 8] = 8'($urandom_range(0, 30) - 15);
          end
        endcase
      end
      apply(a, b, 8'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0), "random");
    end

    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain: %0d results pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
